// File: rtl/store_buffer.sv
// Store buffer: queues committed stores and drains them to the memory bus in order,
// with one write transaction outstanding at a time.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] datafifo_addr_in,
  input  logic [31:0] datafifo_val_in,
  input  logic [1:0]  datafifo_size_in,
  input  logic        datafifo_valid_in,
  output logic        datafifo_full,
  output logic        datafifo_empty,
  output logic [31:0] membus_awaddr,
  output logic        membus_awvalid,
  input  logic        membus_awready,
  output logic [31:0] membus_wdata,
  output logic [3:0]  membus_wstrb,
  output logic        membus_wvalid,
  input  logic        membus_wready,
  input  logic [2:0]  membus_bresp,
  input  logic        membus_bvalid,
  output logic        membus_bready,
  output logic        store_fault_valid,
  output logic [31:0] store_fault_addr
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_addr [DEPTH];
  logic [31:0]   r_val  [DEPTH];
  logic [1:0]    r_size [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_aw_done;
  logic          r_w_done;
  logic          w_aw_done_nxt;
  logic          w_w_done_nxt;
  logic          w_awvalid;
  logic          w_wvalid;
  logic          w_bready;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_head_addr;
  logic [31:0]   w_head_val;
  logic [1:0]    w_head_size;
  logic          r_fault_valid;
  logic [31:0]   r_fault_addr;

  // Full comes only from the registered count, so a same-cycle pop never admits a push.
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_push      = datafifo_valid_in && !w_full;
  assign w_head_addr = r_addr[r_head];
  assign w_head_val  = r_val[r_head];
  assign w_head_size = r_size[r_head];

  assign datafifo_full     = w_full;
  assign datafifo_empty    = (r_count == '0) && (r_state == IDLE);
  assign membus_awaddr     = {w_head_addr[31:2], 2'b00};
  assign membus_awvalid    = w_awvalid;
  assign membus_wvalid     = w_wvalid;
  assign membus_bready     = w_bready;
  assign store_fault_valid = r_fault_valid;
  assign store_fault_addr  = r_fault_addr;

  // Entry payload storage, written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= datafifo_addr_in;
      r_val[r_tail]  <= datafifo_val_in;
      r_size[r_tail] <= datafifo_size_in;
    end
  end

  // Circular pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Drain state register and per-channel handshake flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end

  // Drain next-state and bus handshake controls.
  always_comb begin
    w_state_nxt   = r_state;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    w_awvalid     = 1'b0;
    w_wvalid      = 1'b0;
    w_bready      = 1'b0;
    w_pop         = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) w_state_nxt = SEND;
      end
      SEND: begin
        w_awvalid = !r_aw_done;
        w_wvalid  = !r_w_done;
        if (w_awvalid && membus_awready) w_aw_done_nxt = 1'b1;
        if (w_wvalid && membus_wready)   w_w_done_nxt  = 1'b1;
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_state_nxt   = RESP;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      RESP: begin
        w_bready = 1'b1;
        if (membus_bvalid) begin
          w_pop       = 1'b1;
          w_state_nxt = (r_count > CW'(1)) ? SEND : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Byte-lane strobes and lane-replicated data from the head entry.
  always_comb begin
    membus_wstrb = 4'b1111;
    membus_wdata = w_head_val;
    case (w_head_size)
      2'd0: begin
        membus_wstrb = 4'b0001 << w_head_addr[1:0];
        membus_wdata = {4{w_head_val[7:0]}};
      end
      2'd1: begin
        membus_wstrb = 4'b0011 << {w_head_addr[1], 1'b0};
        membus_wdata = {2{w_head_val[15:0]}};
      end
      default: begin
        membus_wstrb = 4'b1111;
        membus_wdata = w_head_val;
      end
    endcase
  end

  // One-cycle fault pulse carrying the address of a store that got an error response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault_valid <= 1'b0;
      r_fault_addr  <= '0;
    end else begin
      r_fault_valid <= w_pop && (membus_bresp != 3'd0);
      if (w_pop && (membus_bresp != 3'd0)) r_fault_addr <= w_head_addr;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: inputs change and outputs are checked 1ns after each posedge.
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic [31:0] addr_in;
  logic [31:0] val_in;
  logic [1:0]  size_in;
  logic        valid_in;
  logic        full;
  logic        empty;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [2:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        fault_valid;
  logic [31:0] fault_addr;

  int total = 0;
  int bad   = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .datafifo_addr_in  (addr_in),
    .datafifo_val_in   (val_in),
    .datafifo_size_in  (size_in),
    .datafifo_valid_in (valid_in),
    .datafifo_full     (full),
    .datafifo_empty    (empty),
    .membus_awaddr     (awaddr),
    .membus_awvalid    (awvalid),
    .membus_awready    (awready),
    .membus_wdata      (wdata),
    .membus_wstrb      (wstrb),
    .membus_wvalid     (wvalid),
    .membus_wready     (wready),
    .membus_bresp      (bresp),
    .membus_bvalid     (bvalid),
    .membus_bready     (bready),
    .store_fault_valid (fault_valid),
    .store_fault_addr  (fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] v, input logic [1:0] s);
    addr_in  = a;
    val_in   = v;
    size_in  = s;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  // Waits (bounded) for awvalid, checks the head payload, completes the handshake and response.
  task automatic drain_one(input logic [31:0] ea, input logic [3:0] es,
                           input logic [31:0] ed, input logic [2:0] br);
    int n = 0;
    while (!awvalid && n < 20) begin
      tick();
      n++;
    end
    chk("aw_valid", 32'(awvalid), 32'd1);
    chk("aw_addr", awaddr, ea);
    chk("w_strb", 32'(wstrb), 32'(es));
    chk("w_data", wdata, ed);
    tick();
    chk("b_ready", 32'(bready), 32'd1);
    bvalid = 1'b1;
    bresp  = br;
    tick();
    bvalid = 1'b0;
    bresp  = 3'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; addr_in = '0; val_in = '0; size_in = '0; valid_in = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
    tick();
    tick();
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_bready", 32'(bready), 32'd0);
    chk("rst_fault_v", 32'(fault_valid), 32'd0);
    chk("rst_fault_a", fault_addr, 32'd0);
    reset = 1'b0;
    tick();

    // Single word store, full handshake, latency of push to awvalid.
    awready = 1'b1; wready = 1'b1;
    push(32'h0000_1000, 32'hDEAD_BEEF, 2'd2);
    chk("t1_not_empty", 32'(empty), 32'd0);
    chk("t1_aw_late", 32'(awvalid), 32'd0);
    tick();
    chk("t1_aw_up", 32'(awvalid), 32'd1);
    chk("t1_w_up", 32'(wvalid), 32'd1);
    drain_one(32'h0000_1000, 4'b1111, 32'hDEAD_BEEF, 3'd0);
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_aw_idle", 32'(awvalid), 32'd0);

    // Byte then half store, in order.
    push(32'h0000_2003, 32'h0000_00A5, 2'd0);
    push(32'h0000_2002, 32'h0000_1234, 2'd1);
    drain_one(32'h0000_2000, 4'b1000, 32'hA5A5_A5A5, 3'd0);
    drain_one(32'h0000_2000, 4'b1100, 32'h1234_1234, 3'd0);
    chk("t2_empty", 32'(empty), 32'd1);

    // Fill with address channel stalled; fifth push must be dropped.
    awready = 1'b0; wready = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h0000_4000 + 32'(4 * i), 32'h1111_0000 + 32'(i), 2'd2);
    chk("t3_full", 32'(full), 32'd1);
    push(32'h0000_5000, 32'hBAD0_BAD0, 2'd2);
    chk("t3_full_hold", 32'(full), 32'd1);
    chk("t3_head_addr", awaddr, 32'h0000_4000);
    awready = 1'b1;
    for (int i = 0; i < 4; i++) drain_one(32'h0000_4000 + 32'(4 * i), 4'b1111, 32'h1111_0000 + 32'(i), 3'd0);
    chk("t3_empty", 32'(empty), 32'd1);

    // Data channel ready late: awvalid drops after its handshake, wvalid held.
    awready = 1'b1; wready = 1'b0;
    push(32'h0000_6000, 32'hCAFE_F00D, 2'd2);
    tick();
    chk("t4_aw_up", 32'(awvalid), 32'd1);
    chk("t4_w_up", 32'(wvalid), 32'd1);
    tick();
    chk("t4_aw_down", 32'(awvalid), 32'd0);
    chk("t4_w_hold1", 32'(wvalid), 32'd1);
    chk("t4_no_bready", 32'(bready), 32'd0);
    tick();
    chk("t4_w_hold2", 32'(wvalid), 32'd1);
    tick();
    chk("t4_w_hold3", 32'(wvalid), 32'd1);
    wready = 1'b1;
    tick();
    chk("t4_w_down", 32'(wvalid), 32'd0);
    chk("t4_bready", 32'(bready), 32'd1);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk("t4_bready_off", 32'(bready), 32'd0);
    chk("t4_empty", 32'(empty), 32'd1);

    // Error response raises a one-cycle fault; draining continues.
    push(32'h0000_3004, 32'h0000_0055, 2'd2);
    push(32'h0000_3008, 32'h0000_0066, 2'd2);
    drain_one(32'h0000_3004, 4'b1111, 32'h0000_0055, 3'd2);
    chk("t5_fault_v", 32'(fault_valid), 32'd1);
    chk("t5_fault_a", fault_addr, 32'h0000_3004);
    chk("t5_next_aw", awaddr, 32'h0000_3008);
    tick();
    chk("t5_fault_pulse", 32'(fault_valid), 32'd0);
    chk("t5_bready", 32'(bready), 32'd1);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_no_fault", 32'(fault_valid), 32'd0);

    // Reset while waiting for a response with three entries buffered.
    push(32'h0000_7000, 32'h0000_0001, 2'd2);
    push(32'h0000_7004, 32'h0000_0002, 2'd2);
    push(32'h0000_7008, 32'h0000_0003, 2'd2);
    chk("t6_in_resp", 32'(bready), 32'd1);
    reset = 1'b1; bvalid = 1'b1; bresp = 3'd3;
    tick();
    reset = 1'b0; bvalid = 1'b0; bresp = 3'd0;
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_full", 32'(full), 32'd0);
    chk("t6_bready", 32'(bready), 32'd0);
    chk("t6_awvalid", 32'(awvalid), 32'd0);
    chk("t6_no_fault", 32'(fault_valid), 32'd0);
    tick();
    tick();
    chk("t6_stay_empty", 32'(empty), 32'd1);
    chk("t6_stay_idle", 32'(awvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of store entries (power of two, 2..16).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 datafifo_addr_in  in  32  store byte address from commit.
REQ-005 datafifo_val_in  in  32  store data, right-aligned.
REQ-006 datafifo_size_in  in  2  0=byte, 1=half, 2=word, 3=word.
REQ-007 datafifo_valid_in  in  1  push request, one store per cycle.
REQ-008 datafifo_full  out  1  buffer holds DEPTH entries; commit shall not push.
REQ-009 datafifo_empty  out  1  no entries and no bus transaction outstanding.
REQ-010 membus_awaddr  out  32  write address, {addr[31:2],2'b00}.
REQ-011 membus_awvalid / membus_awready  out/in  1/1  address handshake.
REQ-012 membus_wdata  out  32  lane-replicated write data.
REQ-013 membus_wstrb  out  4  byte-lane strobes.
REQ-014 membus_wvalid / membus_wready  out/in  1/1  data handshake.
REQ-015 membus_bresp  in  3  write response; nonzero = error.
REQ-016 membus_bvalid / membus_bready  in/out  1/1  response handshake.
REQ-017 store_fault_valid  out  1  one-cycle pulse on error response.
REQ-018 store_fault_addr  out  32  full byte address of faulting store, valid with pulse.

Function
REQ-019 Storage: circular FIFO, head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, count 0..DEPTH.
REQ-020 Push: when datafifo_valid_in && !datafifo_full, entry written at tail on that edge; count +1 next cycle.
REQ-021 Push while datafifo_full: ignored, no state change; full evaluated from registered count only, so a same-cycle pop does not admit a push.
REQ-022 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-023 datafifo_full = (count == DEPTH); datafifo_empty = (count == 0) && (state == IDLE).
REQ-024 Drain SM states: IDLE, SEND, RESP.
REQ-025 IDLE: go SEND when count != 0; all bus valids/readies low.
REQ-026 SEND: awvalid = !aw_done, wvalid = !w_done; aw_done/w_done set on respective handshake; go RESP on cycle both are done (including both in same cycle); clear both flags on leaving.
REQ-027 RESP: bready = 1; on bvalid pop head; go SEND if count > 1 else IDLE.
REQ-028 Bus outputs (awaddr, wdata, wstrb) driven from head entry combinationally and stable while awvalid or wvalid high.
REQ-029 Strobes: size 0 -> 4'b0001 << addr[1:0]; size 1 -> 4'b0011 << {addr[1],1'b0}; size 2/3 -> 4'b1111.
REQ-030 Data: size 0 -> val[7:0] in all four lanes; size 1 -> {val[15:0],val[15:0]}; size 2/3 -> val.
REQ-031 Error: on RESP pop with bresp != 0, store_fault_valid = 1 for the next cycle only, store_fault_addr = popped entry address; draining continues.
REQ-032 Latency: push at edge E -> awvalid high in cycle after E+1 (IDLE sees count at E+1, SEND at E+2); back-to-back entries add no IDLE cycle.
REQ-033 Stores leave in push order; exactly one transaction outstanding.

Reset
REQ-034 On reset: count, pointers, aw_done, w_done = 0; state = IDLE.
REQ-035 Reset output values: datafifo_full = 0, datafifo_empty = 1, awvalid = wvalid = bready = 0, store_fault_valid = 0, store_fault_addr = 0.
REQ-036 Reset mid-transaction: outstanding store and all buffered entries discarded; bus valids low the cycle after reset asserts; no fault pulse.

Verification
REQ-037 Single word push addr 0x1000, val 0xDEADBEEF, awready=wready=1, bvalid next cycle -> awaddr 0x1000, wstrb 4'b1111, one transaction, datafifo_empty = 1 after pop.
REQ-038 Byte push addr 0x2003 val 0xA5, half push addr 0x2002 val 0x1234 -> wstrb 4'b1000 wdata 0xA5A5A5A5, then wstrb 4'b1100 wdata 0x12341234, in order.
REQ-039 Fill with awready=0: 4 pushes -> datafifo_full = 1, 5th push ignored; release awready -> exactly 4 transactions, original data.
REQ-040 wready asserted 3 cycles after awready -> awvalid drops after its handshake, wvalid held until wready, single bready handshake.
REQ-041 bresp = 2 on store to 0x3004 -> store_fault_valid one cycle, store_fault_addr 0x3004; next entry still drained.
REQ-042 Reset asserted in RESP with 3 entries -> next cycle count 0, datafifo_empty = 1, bready = 0, no fault.
